spi_slave: RTL and testbench
============================

# spi_slave

SPI slave endpoint on the far side of the SPI link from the APB-side SPI master, consuming SCLK/MOSI/SSbar and returning MISO. It oversamples the asynchronous SPI pins with the system clock and deserialises MOSI into words. It serialises a locally supplied transmit word onto MISO and hands each received word to local logic with a one-cycle valid strobe. It is also the bus-functional target used to close the loop on the master in system simulation.

## Interface
- WORD_LENGTH, 8, bits per SPI word; MSB first.
- CPOL, 0, SCLK idle level; must match the master's mode.
- CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
- Clocking and reset (decided): one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  system clock; its frequency is at least 8x SCLK (at least 4 clk per SCLK half period).
- rst_n  in  1  asynchronous active-low reset.
- SCLK  in  1  SPI clock from master; asynchronous to clk.
- MOSI  in  1  serial data from master; asynchronous.
- SSbar  in  1  active-low slave select; asynchronous.
- MISO  out  1  serial data to master.
- tx_data  in  WORD_LENGTH  next word to transmit.
- tx_valid  in  1  tx_data is offered.
- tx_ready  out  1  the transmit holding register is empty.
- rx_data  out  WORD_LENGTH  last complete received word.
- rx_valid  out  1  one-cycle strobe: rx_data has just been updated.
- tx_underrun  out  1  one-cycle strobe: a word started with the holding register empty.
- busy  out  1  slave is selected (synchronised SSbar is low).

## Operation
- Synchronisation: SCLK, MOSI and SSbar each pass through a 2-flop synchroniser, followed by one history flop for edge detection.
  - Synchroniser reset values: SCLK = CPOL, SSbar = 1, MOSI = 0.
- Edge decode (synchronised SCLK):
  - leading edge = transition away from CPOL;
  - trailing edge = transition back to CPOL.
  - Sample edge = leading edge if CPHA=0, else trailing edge. Shift edge = the other edge.
- States:
  - IDLE (SSbar high) -> SELECTED on synchronised SSbar falling.
  - SELECTED -> IDLE on synchronised SSbar rising, from any bit position.
- Transmit holding register:
  - Accepts tx_data when tx_valid && tx_ready; tx_ready then drops.
  - A word start moves the holding register into the tx shift register and sets tx_ready = 1.
  - If the holding register is empty at word start: the shift register loads all zeros and tx_underrun pulses.
- Word start points:
  - CPHA=0: the SSbar-falling detection cycle, and the shift edge following the last sample of a word (back-to-back words).
  - CPHA=1: the first leading edge of each word (bit counter = 0).
- MISO driving:
  - MISO = tx shift register MSB whenever SELECTED.
  - Each shift edge that is not a word start shifts the register left by 1.
  - MISO = 0 in IDLE.
- Receive path:
  - Each sample edge shifts synchronised MOSI into rx_shift LSB and increments the bit counter (width clog2(WORD_LENGTH)+1).
  - When the count reaches WORD_LENGTH: rx_data <= the assembled word, rx_valid pulses, the counter clears.
  - Words continue back-to-back while SSbar stays low.
- Abort: SSbar rising mid-word discards the partial word.
  - No rx_valid; counter and rx_shift clear.
  - rx_data keeps its last value.
  - A word already in the tx shift register is dropped; the holding register is unaffected.
- Overrun: if local logic has not read rx_data before the next word completes, that data is overwritten. No flag is raised.
- Reset values:
  - MISO = 0, rx_data = 0, rx_valid = 0, tx_ready = 1, tx_underrun = 0, busy = 0.
  - Holding register empty; all shift registers and counters zero.

## Timing
- Pin to decision latency: 3 clk. An SCLK or SSbar pin change captured by synchroniser stage 1 on edge N is acted on (shift, sample, load) at edge N+2. MOSI is sampled through the same-depth synchroniser, so data and clock stay aligned.
- rx_valid rises the cycle after the final sample edge is acted on, and lasts exactly 1 clk.
- MISO update: the registered MISO changes at most 3 clk after the SCLK shift-edge pin change. It therefore settles before the master's next sample edge, which is at least 4 clk later.
- CPHA=0 first bit: MISO carries the word MSB 3 clk after SSbar falls at the pin. The master must not issue the first leading edge earlier than 4 clk after SSbar falls.
- Simultaneous tx_valid and word start in the same cycle: the word start sees the holding register empty and underruns. The offered data is then accepted into the holding register for the following word.
- Simultaneous SSbar rise and a sample edge: the abort wins; no rx_valid.
- Reset asserted mid-word: all outputs return to their reset values immediately (asynchronously).

## Test plan
- Mode 0, 8-bit, tx_data=0xA5 preloaded; master sends 0x3C -> rx_data=0x3C with a single rx_valid pulse; master receives 0xA5; tx_ready returns to 1 at the word start.
- Modes 1, 2 and 3 in turn: master sends 0x81, slave sends 0x7E -> both sides exchange correctly; MISO stays 0 while SSbar is high.
- Two back-to-back words with SSbar held low, tx words 0x11 then 0x22, master sends 0xF0 then 0x0F -> two rx_valid pulses carrying 0xF0 then 0x0F; master receives 0x11 then 0x22.
- No tx_valid before the frame -> tx_underrun pulses once; master receives 0x00; rx is still correct.
- SSbar rises after 5 bits -> no rx_valid, rx_data keeps its previous value; the next full frame 0x5A is received correctly.
- rst_n asserted mid-word -> MISO=0, rx_valid=0, tx_ready=1, busy=0 immediately; after release the next frame 0xC3 is received correctly.

Source files
------------

// File: rtl/spi_slave_if.sv
// spi_slave_if: bundles the SPI pins and the local tx/rx handshake of one SPI slave endpoint.
// Ports: SCLK/MOSI/SSbar/MISO on the link side; tx_data/tx_valid/tx_ready, rx_data/rx_valid,
//        tx_underrun and busy on the local side. Modport slave is the endpoint, master is the far side.
interface spi_slave_if #(
  parameter int WORD_LENGTH = 8
);
  logic                   SCLK;
  logic                   MOSI;
  logic                   SSbar;
  logic                   MISO;
  logic [WORD_LENGTH-1:0] tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic [WORD_LENGTH-1:0] rx_data;
  logic                   rx_valid;
  logic                   tx_underrun;
  logic                   busy;

  modport slave (
    input  SCLK, MOSI, SSbar, tx_data, tx_valid,
    output MISO, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport master (
    output SCLK, MOSI, SSbar, tx_data, tx_valid,
    input  MISO, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: SPI slave endpoint; oversamples SCLK/MOSI/SSbar on clk, deserialises MOSI into words and
//            serialises a one-deep transmit holding register onto MISO (MSB first, mode set by CPOL/CPHA).
// Ports: clk, rst_n (async, active-low), bus (spi_slave_if.slave). Pin change to action is 3 clk;
//        rx_valid/tx_underrun are 1-clk strobes; tx_data is taken when tx_valid && tx_ready.
module spi_slave #(
  parameter int WORD_LENGTH = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_slave_if.slave bus
);
  localparam int              CW       = $clog2(WORD_LENGTH) + 1;
  localparam logic [0:0]      IDLE     = 1'b0;
  localparam logic [0:0]      SELECTED = 1'b1;
  localparam logic            CPOL_L   = (CPOL != 0);
  localparam logic            CPHA_L   = (CPHA != 0);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WORD_LENGTH - 1);

  // synchronisers plus one history stage for edge detection
  logic sclk_s1, sclk_s2, sclk_d;
  logic ss_s1, ss_s2, ss_d;
  logic mosi_s1, mosi_s2;

  logic [0:0]             state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [WORD_LENGTH-1:0] rx_shift, rx_shift_nxt;
  logic [WORD_LENGTH-1:0] tx_shift, tx_shift_nxt;
  logic [WORD_LENGTH-1:0] rx_word;
  logic [WORD_LENGTH-1:0] hold;
  logic                   hold_full;
  logic [WORD_LENGTH-1:0] rx_data_q;
  logic                   miso_q, rx_valid_q, underrun_q;

  logic lead, trail, sample_edge, shift_edge;
  logic ss_fall, ss_rise, active, word_start, sample_act, word_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1 <= CPOL_L;
      sclk_s2 <= CPOL_L;
      sclk_d  <= CPOL_L;
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      ss_d    <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= bus.SCLK;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      ss_s1   <= bus.SSbar;
      ss_s2   <= ss_s1;
      ss_d    <= ss_s2;
      mosi_s1 <= bus.MOSI;
      mosi_s2 <= mosi_s1;
    end
  end

  always_comb begin
    lead        = (sclk_s2 != CPOL_L) && (sclk_d == CPOL_L);
    trail       = (sclk_s2 == CPOL_L) && (sclk_d != CPOL_L);
    sample_edge = CPHA_L ? trail : lead;
    shift_edge  = CPHA_L ? lead : trail;
    ss_fall     = ss_d & ~ss_s2;
    ss_rise     = ~ss_d & ss_s2;
    // a deselect in the same cycle as any SCLK edge overrides that edge
    active      = (state == SELECTED) && !ss_rise;
    // CPHA=0 must present the MSB before the first SCLK edge, so selection itself opens a word;
    // after that, a shift edge with the counter at zero can only follow a completed word.
    word_start  = (active && shift_edge && (cnt == '0)) ||
                  (!CPHA_L && (state == IDLE) && ss_fall);
    sample_act  = active && sample_edge;
    word_done   = sample_act && (cnt == CNT_LAST);
    rx_word     = {rx_shift[WORD_LENGTH-2:0], mosi_s2};

    state_nxt = state;
    if (ss_rise) begin
      state_nxt = IDLE;
    end else if (ss_fall) begin
      state_nxt = SELECTED;
    end

    tx_shift_nxt = tx_shift;
    if (ss_rise) begin
      tx_shift_nxt = '0;
    end else if (word_start) begin
      tx_shift_nxt = hold_full ? hold : '0;
    end else if (active && shift_edge) begin
      tx_shift_nxt = {tx_shift[WORD_LENGTH-2:0], 1'b0};
    end

    cnt_nxt      = cnt;
    rx_shift_nxt = rx_shift;
    if (ss_rise) begin
      cnt_nxt      = '0;
      rx_shift_nxt = '0;
    end else if (sample_act) begin
      cnt_nxt      = word_done ? '0 : cnt + CW'(1);
      rx_shift_nxt = rx_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      miso_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      hold       <= '0;
      hold_full  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rx_shift   <= rx_shift_nxt;
      tx_shift   <= tx_shift_nxt;
      // registered from next-state values so MISO moves on the same edge as the shift register
      miso_q     <= (state_nxt == SELECTED) ? tx_shift_nxt[WORD_LENGTH-1] : 1'b0;
      rx_valid_q <= word_done;
      if (word_done) begin
        rx_data_q <= rx_word;
      end
      underrun_q <= word_start && !hold_full;
      // a word start empties the holding register; an offer in that same cycle saw it empty
      // too late for this word and is kept for the next one
      if (word_start) begin
        hold_full <= 1'b0;
      end
      if (bus.tx_valid && !hold_full) begin
        hold      <= bus.tx_data;
        hold_full <= 1'b1;
      end
    end
  end

  assign bus.MISO        = miso_q;
  assign bus.tx_ready    = !hold_full;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.busy        = (state == SELECTED);
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave, one instance per SPI mode (index = 2*CPOL + CPHA).
// Ports: none; drives SCLK/MOSI/SSbar as an SPI master plus the local tx handshake of each instance.
// Each task runs one scenario and compares against hand-computed words.
module tb_spi_slave;
  localparam int HALF = 6;  // clk per SCLK half period

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sclk, mosi, ssbar, tx_valid;
  logic [7:0] tx_data [4];
  logic [3:0] miso, tx_ready, rx_valid, tx_underrun, busy;
  logic [7:0] rx_data [4];

  int         n_cmp = 0;
  int         n_fail = 0;
  int         rxv_cnt [4];
  int         unr_cnt [4];
  logic [7:0] rx_log [4][4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : m
    spi_slave_if #(.WORD_LENGTH(8)) bus ();
    spi_slave #(.WORD_LENGTH(8), .CPOL(g / 2), .CPHA(g % 2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
    assign bus.SCLK       = sclk[g];
    assign bus.MOSI       = mosi[g];
    assign bus.SSbar      = ssbar[g];
    assign bus.tx_data    = tx_data[g];
    assign bus.tx_valid   = tx_valid[g];
    assign miso[g]        = bus.MISO;
    assign tx_ready[g]    = bus.tx_ready;
    assign rx_valid[g]    = bus.rx_valid;
    assign tx_underrun[g] = bus.tx_underrun;
    assign busy[g]        = bus.busy;
    assign rx_data[g]     = bus.rx_data;
  end

  // strobe monitor: counts pulses and logs each received word
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid[i] === 1'b1) begin
        rx_log[i][rxv_cnt[i] % 4] <= rx_data[i];
        rxv_cnt[i] <= rxv_cnt[i] + 1;
      end
      if (tx_underrun[i] === 1'b1) begin
        unr_cnt[i] <= unr_cnt[i] + 1;
      end
    end
  end

  task automatic offer(input int md, input logic [7:0] d);
    @(negedge clk);
    tx_data[md]  = d;
    tx_valid[md] = 1'b1;
    @(negedge clk);
    tx_valid[md] = 1'b0;
  endtask

  task automatic ss_low(input int md);
    @(negedge clk);
    ssbar[md] = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic ss_high(input int md);
    repeat (HALF) @(negedge clk);
    ssbar[md] = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // SPI master for nbits bits of one word, MSB first; returns what it sampled on MISO
  task automatic spi_word(input int md, input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    logic cpol, cpha;
    int   b;
    cpol = (md >= 2);
    cpha = (md % 2 == 1);
    mi   = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      b = 7 - i;
      if (!cpha) begin
        mosi[md] = mo[b];
        repeat (HALF) @(negedge clk);
        mi[b]    = miso[md];
        sclk[md] = ~cpol;
        repeat (HALF) @(negedge clk);
        sclk[md] = cpol;
      end else begin
        sclk[md] = ~cpol;
        mosi[md] = mo[b];
        repeat (HALF) @(negedge clk);
        mi[b]    = miso[md];
        sclk[md] = cpol;
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (miso[i] !== 1'b0) begin n_fail++; $display("FAIL reset_miso[%0d]: got %b want 0", i, miso[i]); end
      n_cmp++; if (tx_ready[i] !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready[%0d]: got %b want 1", i, tx_ready[i]); end
      n_cmp++; if (rx_valid[i] !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid[%0d]: got %b want 0", i, rx_valid[i]); end
      n_cmp++; if (busy[i] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy[i]); end
      n_cmp++; if (tx_underrun[i] !== 1'b0) begin n_fail++; $display("FAIL reset_underrun[%0d]: got %b want 0", i, tx_underrun[i]); end
      n_cmp++; if (rx_data[i] !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data[%0d]: got %h want 00", i, rx_data[i]); end
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mode0_basic;
    logic [7:0] got;
    int         n0;
    offer(0, 8'hA5);
    n_cmp++; if (tx_ready[0] !== 1'b0) begin n_fail++; $display("FAIL m0_ready_after_load: got %b want 0", tx_ready[0]); end
    ss_low(0);
    n_cmp++; if (tx_ready[0] !== 1'b1) begin n_fail++; $display("FAIL m0_ready_at_word_start: got %b want 1", tx_ready[0]); end
    n_cmp++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL m0_busy: got %b want 1", busy[0]); end
    n0 = rxv_cnt[0];
    spi_word(0, 8'h3C, 8, got);
    ss_high(0);
    n_cmp++; if (got !== 8'hA5) begin n_fail++; $display("FAIL m0_master_rx: got %h want a5", got); end
    n_cmp++; if (rx_data[0] !== 8'h3C) begin n_fail++; $display("FAIL m0_rx_data: got %h want 3c", rx_data[0]); end
    n_cmp++; if (rxv_cnt[0] - n0 != 1) begin n_fail++; $display("FAIL m0_rx_valid_pulses: got %0d want 1", rxv_cnt[0] - n0); end
    n_cmp++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL m0_busy_after: got %b want 0", busy[0]); end
  endtask

  task automatic test_modes_123;
    logic [7:0] got;
    int         n0;
    for (int md = 1; md < 4; md++) begin
      offer(md, 8'h7E);
      // SCLK activity while deselected must not move MISO or the receiver
      n0 = rxv_cnt[md];
      for (int k = 0; k < 4; k++) begin
        sclk[md] = ~sclk[md];
        repeat (HALF) @(negedge clk);
        n_cmp++; if (miso[md] !== 1'b0) begin n_fail++; $display("FAIL m%0d_idle_miso: got %b want 0", md, miso[md]); end
      end
      ss_low(md);
      spi_word(md, 8'h81, 8, got);
      ss_high(md);
      n_cmp++; if (got !== 8'h7E) begin n_fail++; $display("FAIL m%0d_master_rx: got %h want 7e", md, got); end
      n_cmp++; if (rx_data[md] !== 8'h81) begin n_fail++; $display("FAIL m%0d_rx_data: got %h want 81", md, rx_data[md]); end
      n_cmp++; if (rxv_cnt[md] - n0 != 1) begin n_fail++; $display("FAIL m%0d_rx_valid_pulses: got %0d want 1", md, rxv_cnt[md] - n0); end
      n_cmp++; if (miso[md] !== 1'b0) begin n_fail++; $display("FAIL m%0d_miso_deselected: got %b want 0", md, miso[md]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] g1, g2;
    int         n0;
    offer(0, 8'h11);
    ss_low(0);
    offer(0, 8'h22);
    n0 = rxv_cnt[0];
    spi_word(0, 8'hF0, 8, g1);
    spi_word(0, 8'h0F, 8, g2);
    ss_high(0);
    n_cmp++; if (g1 !== 8'h11) begin n_fail++; $display("FAIL b2b_master_rx1: got %h want 11", g1); end
    n_cmp++; if (g2 !== 8'h22) begin n_fail++; $display("FAIL b2b_master_rx2: got %h want 22", g2); end
    n_cmp++; if (rxv_cnt[0] - n0 != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", rxv_cnt[0] - n0); end
    n_cmp++; if (rx_log[0][n0 % 4] !== 8'hF0) begin n_fail++; $display("FAIL b2b_word1: got %h want f0", rx_log[0][n0 % 4]); end
    n_cmp++; if (rx_log[0][(n0 + 1) % 4] !== 8'h0F) begin n_fail++; $display("FAIL b2b_word2: got %h want 0f", rx_log[0][(n0 + 1) % 4]); end
  endtask

  // mode 1 opens its only word on the first leading edge, so an empty holding register underruns once
  task automatic test_underrun;
    logic [7:0] got;
    int         u0, n0;
    u0 = unr_cnt[1];
    n0 = rxv_cnt[1];
    ss_low(1);
    spi_word(1, 8'h96, 8, got);
    ss_high(1);
    n_cmp++; if (unr_cnt[1] - u0 != 1) begin n_fail++; $display("FAIL underrun_pulses: got %0d want 1", unr_cnt[1] - u0); end
    n_cmp++; if (got !== 8'h00) begin n_fail++; $display("FAIL underrun_master_rx: got %h want 00", got); end
    n_cmp++; if (rx_data[1] !== 8'h96) begin n_fail++; $display("FAIL underrun_rx_data: got %h want 96", rx_data[1]); end
    n_cmp++; if (rxv_cnt[1] - n0 != 1) begin n_fail++; $display("FAIL underrun_rx_pulses: got %0d want 1", rxv_cnt[1] - n0); end
  endtask

  task automatic test_abort;
    logic [7:0] got;
    int         n0;
    n0 = rxv_cnt[0];
    ss_low(0);
    spi_word(0, 8'hFF, 5, got);
    ss_high(0);
    n_cmp++; if (rxv_cnt[0] != n0) begin n_fail++; $display("FAIL abort_no_valid: got %0d pulses want 0", rxv_cnt[0] - n0); end
    n_cmp++; if (rx_data[0] !== 8'h0F) begin n_fail++; $display("FAIL abort_rx_data_kept: got %h want 0f", rx_data[0]); end
    ss_low(0);
    spi_word(0, 8'h5A, 8, got);
    ss_high(0);
    n_cmp++; if (rx_data[0] !== 8'h5A) begin n_fail++; $display("FAIL abort_next_frame: got %h want 5a", rx_data[0]); end
    n_cmp++; if (rxv_cnt[0] - n0 != 1) begin n_fail++; $display("FAIL abort_next_pulses: got %0d want 1", rxv_cnt[0] - n0); end
  endtask

  task automatic test_reset_mid_word;
    logic [7:0] got;
    int         n0;
    offer(0, 8'hFF);
    ss_low(0);
    offer(0, 8'h33);
    spi_word(0, 8'hAA, 3, got);
    repeat (4) @(negedge clk);
    n_cmp++; if (miso[0] !== 1'b1) begin n_fail++; $display("FAIL midword_miso_before: got %b want 1", miso[0]); end
    n_cmp++; if (tx_ready[0] !== 1'b0) begin n_fail++; $display("FAIL midword_ready_before: got %b want 0", tx_ready[0]); end
    n_cmp++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL midword_busy_before: got %b want 1", busy[0]); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (miso[0] !== 1'b0) begin n_fail++; $display("FAIL midword_reset_miso: got %b want 0", miso[0]); end
    n_cmp++; if (rx_valid[0] !== 1'b0) begin n_fail++; $display("FAIL midword_reset_rx_valid: got %b want 0", rx_valid[0]); end
    n_cmp++; if (tx_ready[0] !== 1'b1) begin n_fail++; $display("FAIL midword_reset_ready: got %b want 1", tx_ready[0]); end
    n_cmp++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL midword_reset_busy: got %b want 0", busy[0]); end
    ssbar[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n0 = rxv_cnt[0];
    ss_low(0);
    spi_word(0, 8'hC3, 8, got);
    ss_high(0);
    n_cmp++; if (rx_data[0] !== 8'hC3) begin n_fail++; $display("FAIL after_reset_rx_data: got %h want c3", rx_data[0]); end
    n_cmp++; if (rxv_cnt[0] - n0 != 1) begin n_fail++; $display("FAIL after_reset_pulses: got %0d want 1", rxv_cnt[0] - n0); end
  endtask

  initial begin
    rst_n    = 1'b0;
    sclk     = 4'b1100;
    mosi     = 4'b0000;
    ssbar    = 4'b1111;
    tx_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tx_data[i] = 8'h00;
    end
    test_reset();
    test_mode0_basic();
    test_modes_123();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
